// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions for the iterative multiplier: operand width,
// op encodings, FSM state type and iteration counter type.
package exe_pkg;

   localparam int unsigned MUL_W   = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned SHIFT_W = 6;

   localparam logic MUL_OP_LO = 1'b0;
   localparam logic MUL_OP_HI = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE,
      FAST
   } mul_state_t;

   // Wide enough for the longest run, 32 iterations at one bit per cycle.
   typedef logic [$clog2(MUL_W+1)-1:0] mul_iter_cnt_t;

endpackage

// File: rtl/mul_iter_if.sv
// Issue/writeback bus between the EXE issue logic and the iterative multiplier.
interface mul_iter_if;
   import exe_pkg::*;

   logic                mul_en_in;
   logic                mul_op;
   logic                mul_sign;
   logic [MUL_W-1:0]    mul_sr0;
   logic [MUL_W-1:0]    mul_sr1;
   logic [REG_AW-1:0]   mul_addr_in;
   logic                mul_en_out;
   logic                stall_because_mul;
   logic [MUL_W-1:0]    mul_result;
   logic [REG_AW-1:0]   mul_addr_out;

   modport master (
      output mul_en_in, mul_op, mul_sign, mul_sr0, mul_sr1, mul_addr_in,
      input  mul_en_out, stall_because_mul, mul_result, mul_addr_out
   );

   modport slave (
      input  mul_en_in, mul_op, mul_sign, mul_sr0, mul_sr1, mul_addr_in,
      output mul_en_out, stall_because_mul, mul_result, mul_addr_out
   );

endinterface

// File: rtl/mul_step.sv
// One shift-add step: adds mcand * digit, shifted into place, to the
// 64-bit unsigned accumulator.
module mul_step
   import exe_pkg::*;
#(
   parameter int unsigned BPC = 2
) (
   input  logic [2*MUL_W-1:0] acc,
   input  logic [MUL_W-1:0]   mcand,
   input  logic [BPC-1:0]     mplr_digit,
   input  logic [SHIFT_W-1:0] shift,
   output logic [2*MUL_W-1:0] acc_nxt
);

   logic [MUL_W+BPC-1:0] pp;

   always_comb begin
      pp      = {{BPC{1'b0}}, mcand} * {{MUL_W{1'b0}}, mplr_digit};
      acc_nxt = acc + ({{(MUL_W-BPC){1'b0}}, pp} << shift);
   end

endmodule

// File: rtl/mul_iter.sv
// Iterative 32x32 multiplier: unsigned shift-add on operand magnitudes,
// BPC multiplier bits per cycle, sign applied to the 64-bit product at the end.
module mul_iter
   import exe_pkg::*;
#(
   parameter int unsigned BPC = 2
) (
   input  logic       clk,
   input  logic       rstn,
   mul_iter_if.slave  bus
);

   localparam mul_iter_cnt_t N = mul_iter_cnt_t'(MUL_W / BPC);

   mul_state_t          state;
   mul_iter_cnt_t       cnt;
   logic [MUL_W-1:0]    mcand;
   logic [MUL_W-1:0]    mplr;
   logic [2*MUL_W-1:0]  acc;
   logic [2*MUL_W-1:0]  acc_nxt;
   logic [2*MUL_W-1:0]  prod;
   logic [SHIFT_W-1:0]  shift;
   logic                neg;
   logic                op;
   logic [REG_AW-1:0]   addr;
   logic [MUL_W-1:0]    mag0;
   logic [MUL_W-1:0]    mag1;
   logic                zero_opnd;

   // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
   always_comb begin
      mag0      = (bus.mul_sign && bus.mul_sr0[MUL_W-1]) ? -bus.mul_sr0 : bus.mul_sr0;
      mag1      = (bus.mul_sign && bus.mul_sr1[MUL_W-1]) ? -bus.mul_sr1 : bus.mul_sr1;
      zero_opnd = (bus.mul_sr0 == '0) || (bus.mul_sr1 == '0);
      prod      = neg ? -acc : acc;
   end

   mul_step #(
      .BPC (BPC)
   ) u_step (
      .acc        (acc),
      .mcand      (mcand),
      .mplr_digit (mplr[BPC-1:0]),
      .shift      (shift),
      .acc_nxt    (acc_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state                 <= IDLE;
         cnt                   <= '0;
         mcand                 <= '0;
         mplr                  <= '0;
         acc                   <= '0;
         shift                 <= '0;
         neg                   <= 1'b0;
         op                    <= 1'b0;
         addr                  <= '0;
         bus.mul_en_out        <= 1'b0;
         bus.stall_because_mul <= 1'b0;
         bus.mul_result        <= '0;
         bus.mul_addr_out      <= '0;
      end else begin
         bus.mul_en_out <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.mul_en_in) begin
                  mcand <= mag0;
                  mplr  <= mag1;
                  neg   <= bus.mul_sign & (bus.mul_sr0[MUL_W-1] ^ bus.mul_sr1[MUL_W-1]);
                  op    <= bus.mul_op;
                  addr  <= bus.mul_addr_in;
                  acc   <= '0;
                  shift <= '0;
                  cnt   <= N;
                  state <= zero_opnd ? FAST : BUSY;
               end
            end
            BUSY: begin
               acc                   <= acc_nxt;
               mplr                  <= mplr >> BPC;
               shift                 <= shift + SHIFT_W'(BPC);
               cnt                   <= cnt - 1'b1;
               bus.stall_because_mul <= 1'b1;
               if (cnt == mul_iter_cnt_t'(1)) state <= DONE;
            end
            DONE: begin
               bus.mul_result        <= (op == MUL_OP_HI) ? prod[2*MUL_W-1:MUL_W] : prod[MUL_W-1:0];
               bus.mul_addr_out      <= addr;
               bus.mul_en_out        <= 1'b1;
               bus.stall_because_mul <= 1'b0;
               state                 <= IDLE;
            end
            FAST: begin
               bus.mul_result   <= '0;
               bus.mul_addr_out <= addr;
               bus.mul_en_out   <= 1'b1;
               state            <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
